normalize_fp_pipe: RTL and testbench
====================================

Name: normalize_fp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle FP add/sub normalizer in the red_team FP_units datapath.
- Takes the raw aligned mantissa sum and pre-normalisation exponent from the adder front end and produces a normalised mantissa, adjusted exponent, underflow/overflow flags and G/R/S bits for the rounder.
- Format-generic through EXP_W/MAN_W (fp16/fp32/fp64).
- Two-stage valid/ready pipeline with a tag passthrough, so several operations can be in flight under back-pressure.

Parameters:
- EXP_W, 8, biased exponent width of the target format.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- SUM_W, 2*(MAN_W+1), width of mantissa_sum; bit SUM_W-1 is the hidden-bit position.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept this cycle
- sign1  in  1  sign of operand 1
- sign2  in  1  sign of operand 2
- zero  in  1  at least one operand is zero (forces add path)
- carry  in  1  carry-out of the mantissa adder
- mantissa_sum  in  SUM_W  aligned adder result
- exp_res  in  EXP_W+2  pre-normalisation exponent (unsigned)
- sticky_in  in  1  sticky from alignment shift
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- mantissa_norm  out  MAN_W  normalised fraction
- exp_norm  out  EXP_W+2  normalised exponent
- underflow  out  1  exponent would drop below 1; result denormalised
- overflow  out  1  exp_norm >= 2^EXP_W-1
- grs  out  3  {G,R,S}; S already ORed with sticky_in
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: s1_valid, out_valid=0; all datapath outputs 0; in_ready=1 in the cycle after reset. Reset mid-operation flushes both stages; no result is emitted.
- Handshake:
  - Transfer happens when valid&ready.
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready).
  - Latency from input accept to out_valid is 2 cycles. Throughput is 1 operation per cycle.
  - Outputs hold stable while out_valid & ~out_ready.
- Stage 1 (decode):
  - Leading-zero count lzc over mantissa_sum from bit SUM_W-1; lzc=SUM_W when the sum is 0.
  - Select mode and shift amount k; register mode, k, candidate exponent, sum, sticky and tag.
- Stage 2 (shift/extract):
  - v = mantissa_sum << k, or the right-shift form for mode C.
  - mantissa_norm = v[SUM_W-2 -: MAN_W]; G = next bit; R = the bit after; S = OR of the remaining lower bits | sticky_in.
  - Result is registered to the outputs.
- Mode selection, first match wins:
  - SUB (exp_res==0): shift 0; exp_norm = mantissa_sum[SUM_W-1] ? 1 : 0.
  - ZERO (mantissa_sum==0 and ~carry): mantissa, exp, grs, flags all 0.
  - C (add path (sign1==sign2 | zero) and carry): mantissa_norm = mantissa_sum[SUM_W-1 -: MAN_W]; G/R/S taken from the bits below that; exp_norm = exp_res+1.
  - A (add path, ~carry): shift 0; exp_norm = mantissa_sum[SUM_W-1] ? exp_res : 0.
  - S (subtract path):
    - If lzc < exp_res: k = lzc, exp_norm = exp_res-lzc.
    - Otherwise: underflow=1, exp_norm=0, k = exp_res-1.
- overflow = 1 when exp_norm >= 2^EXP_W-1 in any mode. exp_norm is not saturated; the rounder handles inf.
- underflow = 1 only in the subtract-path underflow case.
- All exponent arithmetic is EXP_W+2 bits unsigned; the subtract path never produces wrap-around.

Test Plan:
- Carry/add path: exp_res=127, carry=1, sum=48'hC000_0000_0001, same signs -> after 2 cycles mantissa_norm=23'h600000, exp_norm=128, grs=3'b001, flags 0. Repeat with exp_res=254 -> exp_norm=255, overflow=1.
- Cancellation: sign1≠sign2, exp_res=100, sum bits 44 and 20 set -> mantissa_norm=0, exp_norm=97, grs=3'b100, underflow=0.
- Underflow: sign1≠sign2, exp_res=5, only bit 40 set (lzc=7) -> k=4, mantissa_norm=23'h100000, exp_norm=0, underflow=1. Also exp_res=1 with bit 47 clear -> k=0, exp_norm=0.
- Zero result: subtract, sum=0, exp_res=50, sticky_in=0 -> mantissa 0, exp 0, grs 000, flags 0.
- Back-pressure: out_ready=0, three back-to-back inputs with tags 1,2,3 -> in_ready=0 after two are accepted; outputs are stable. Raising out_ready then emits tags 1,2,3 in order on consecutive cycles.
- Reset with both stages valid -> next cycle out_valid=0, in_ready=1, all outputs 0; the following input completes with 2-cycle latency.

Source files
------------

// File: rtl/normalize_fp_pipe.sv
// ---------------------------------------------------------------------------
// normalize_fp_pipe
//   Two-stage valid/ready normaliser for the FP add/sub datapath. Takes the
//   aligned mantissa sum and pre-normalisation exponent from the adder front
//   end and produces the normalised fraction, adjusted exponent,
//   underflow/overflow flags and guard/round/sticky bits for the rounder.
//
//   Stage 1 (decode): leading-zero count, mode select, shift amount and
//                     candidate exponent.
//   Stage 2 (shift) : shift, field extraction, overflow detection.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     input handshake (in_ready combinational on out_ready)
//   sign1, sign2, zero      operand signs, "an operand is zero" (forces add path)
//   carry                   carry-out of the mantissa adder
//   mantissa_sum [SUM_W]    aligned adder result, bit SUM_W-1 = hidden bit
//   exp_res [EXP_W+2]       pre-normalisation exponent (unsigned)
//   sticky_in               sticky from the alignment shift
//   in_tag / out_tag        opaque tag carried with each operation
//   out_valid / out_ready   output handshake
//   mantissa_norm [MAN_W]   normalised fraction (hidden bit dropped)
//   exp_norm [EXP_W+2]      normalised exponent (not saturated)
//   underflow, overflow     exponent range flags
//   grs [3]                 {guard, round, sticky}
// ---------------------------------------------------------------------------
module normalize_fp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SUM_W = 2 * (MAN_W + 1),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign1,
  input  logic             sign2,
  input  logic             zero,
  input  logic             carry,
  input  logic [SUM_W-1:0] mantissa_sum,
  input  logic [EXP_W+1:0] exp_res,
  input  logic             sticky_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] mantissa_norm,
  output logic [EXP_W+1:0] exp_norm,
  output logic             underflow,
  output logic             overflow,
  output logic [2:0]       grs,
  output logic [TAG_W-1:0] out_tag
);

  localparam int XW   = EXP_W + 2;
  localparam int LZ_W = $clog2(SUM_W + 1);
  localparam int CW   = (XW > LZ_W) ? XW : LZ_W;
  localparam logic [XW-1:0] OVF_LIM = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    MODE_SUB,      // exp_res == 0: already denormal, no shift
    MODE_ZERO,     // exact zero result
    MODE_CARRY,    // add with carry-out: effective right shift by one
    MODE_ADD,      // add without carry: no shift
    MODE_SUBTRACT  // subtract: left shift by leading-zero count
  } mode_t;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = ~out_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;

  // -------------------------------------------------------------------------
  // Stage 1: leading-zero count and mode select
  // -------------------------------------------------------------------------
  logic [LZ_W-1:0] lzc_next;

  // Later (higher) set bits overwrite earlier ones, leaving the count for
  // the most significant one; an all-zero sum keeps the SUM_W default.
  always_comb begin
    lzc_next = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (mantissa_sum[i]) lzc_next = LZ_W'(SUM_W - 1 - i);
    end
  end

  mode_t           mode_next;
  logic [LZ_W-1:0] k_next;
  logic [XW-1:0]   exp_next;
  logic            uf_next;
  logic            add_path;

  assign add_path = (sign1 == sign2) | zero;

  always_comb begin
    mode_next = MODE_SUBTRACT;
    k_next    = '0;
    exp_next  = '0;
    uf_next   = 1'b0;
    if (exp_res == '0) begin
      mode_next = MODE_SUB;
      exp_next  = XW'(mantissa_sum[SUM_W-1]);
    end else if ((mantissa_sum == '0) && !carry) begin
      mode_next = MODE_ZERO;
    end else if (add_path && carry) begin
      mode_next = MODE_CARRY;
      exp_next  = exp_res + XW'(1);
    end else if (add_path) begin
      mode_next = MODE_ADD;
      exp_next  = mantissa_sum[SUM_W-1] ? exp_res : '0;
    end else if (CW'(lzc_next) < CW'(exp_res)) begin
      k_next   = lzc_next;
      exp_next = exp_res - XW'(lzc_next);
    end else begin
      // Full normalisation would take the exponent below 1: shift only as
      // far as exponent 1 allows and flag the denormal. Here exp_res <= lzc,
      // so exp_res-1 always fits the shift field.
      uf_next = 1'b1;
      k_next  = LZ_W'(exp_res - XW'(1));
    end
  end

  mode_t            s1_mode_reg;
  logic [LZ_W-1:0]  s1_k_reg;
  logic [XW-1:0]    s1_exp_reg;
  logic             s1_uf_reg;
  logic [SUM_W-1:0] s1_sum_reg;
  logic             s1_sticky_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  // -------------------------------------------------------------------------
  // Stage 2: shift and field extraction
  // -------------------------------------------------------------------------
  // The hidden bit lands on SUM_W-1 after the shift and is dropped, so only
  // the bits below it are kept.
  logic [SUM_W-2:0] shifted;
  logic [MAN_W-1:0] mant_next;
  logic [2:0]       grs_next;

  assign shifted = (SUM_W - 1)'(s1_sum_reg << s1_k_reg);

  always_comb begin
    mant_next = '0;
    grs_next  = '0;
    case (s1_mode_reg)
      MODE_ZERO: begin
        mant_next = '0;
        grs_next  = '0;
      end
      MODE_CARRY: begin
        // Carry-out means the true hidden bit is the carry itself, so the
        // fraction starts at the top of the sum (a right shift by one).
        mant_next = s1_sum_reg[SUM_W-1 -: MAN_W];
        grs_next  = {s1_sum_reg[SUM_W-1-MAN_W],
                     s1_sum_reg[SUM_W-2-MAN_W],
                     (|s1_sum_reg[SUM_W-3-MAN_W:0]) | s1_sticky_reg};
      end
      default: begin
        mant_next = shifted[SUM_W-2 -: MAN_W];
        grs_next  = {shifted[SUM_W-2-MAN_W],
                     shifted[SUM_W-3-MAN_W],
                     (|shifted[SUM_W-4-MAN_W:0]) | s1_sticky_reg};
      end
    endcase
  end

  logic [MAN_W-1:0] mant_reg;
  logic [XW-1:0]    exp_reg;
  logic             uf_reg;
  logic             of_reg;
  logic [2:0]       grs_reg;
  logic [TAG_W-1:0] tag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_mode_reg   <= MODE_ZERO;
      s1_k_reg      <= '0;
      s1_exp_reg    <= '0;
      s1_uf_reg     <= 1'b0;
      s1_sum_reg    <= '0;
      s1_sticky_reg <= 1'b0;
      s1_tag_reg    <= '0;
      out_valid_reg <= 1'b0;
      mant_reg      <= '0;
      exp_reg       <= '0;
      uf_reg        <= 1'b0;
      of_reg        <= 1'b0;
      grs_reg       <= '0;
      tag_reg       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_mode_reg   <= mode_next;
          s1_k_reg      <= k_next;
          s1_exp_reg    <= exp_next;
          s1_uf_reg     <= uf_next;
          s1_sum_reg    <= mantissa_sum;
          s1_sticky_reg <= sticky_in;
          s1_tag_reg    <= in_tag;
        end
      end
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          mant_reg <= mant_next;
          exp_reg  <= s1_exp_reg;
          uf_reg   <= s1_uf_reg;
          of_reg   <= (s1_exp_reg >= OVF_LIM);
          grs_reg  <= grs_next;
          tag_reg  <= s1_tag_reg;
        end
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign mantissa_norm = mant_reg;
  assign exp_norm      = exp_reg;
  assign underflow     = uf_reg;
  assign overflow      = of_reg;
  assign grs           = grs_reg;
  assign out_tag       = tag_reg;

endmodule

// File: tb/tb_normalize_fp_pipe.sv
// ---------------------------------------------------------------------------
// tb_normalize_fp_pipe
//   Scoreboard bench for normalize_fp_pipe at the fp32 defaults. Expected
//   results are pushed when an input is accepted and compared when the DUT
//   hands a result over. Directed vectors carry hand-computed expectations;
//   random vectors use a reference model written from the mode rules.
// ---------------------------------------------------------------------------
module tb_normalize_fp_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SUM_W = 48;
  localparam int TAG_W = 4;
  localparam int XW    = EXP_W + 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             sign1, sign2, zero, carry;
  logic [SUM_W-1:0] mantissa_sum;
  logic [XW-1:0]    exp_res;
  logic             sticky_in;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] mantissa_norm;
  logic [XW-1:0]    exp_norm;
  logic             underflow, overflow;
  logic [2:0]       grs;
  logic [TAG_W-1:0] out_tag;

  normalize_fp_pipe #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .SUM_W(SUM_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign1(sign1), .sign2(sign2), .zero(zero), .carry(carry),
    .mantissa_sum(mantissa_sum), .exp_res(exp_res), .sticky_in(sticky_in),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .mantissa_norm(mantissa_norm), .exp_norm(exp_norm),
    .underflow(underflow), .overflow(overflow), .grs(grs), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MAN_W-1:0] mant;
    logic [XW-1:0]    e;
    logic             uf;
    logic             of;
    logic [2:0]       grs;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t sb[$];
  int   pop_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   rand_bp  = 1'b0;
  res_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  function automatic res_t mk(input logic [MAN_W-1:0] m, input int e, input logic uf,
                              input logic of, input logic [2:0] g, input logic [TAG_W-1:0] t);
    res_t r;
    r.mant = m; r.e = XW'(e); r.uf = uf; r.of = of; r.grs = g; r.tag = t;
    return r;
  endfunction

  // Reference model written directly from the mode table.
  function automatic res_t model(input logic s1, input logic s2, input logic z, input logic c,
                                 input logic [SUM_W-1:0] sum, input logic [XW-1:0] er,
                                 input logic st, input logic [TAG_W-1:0] tag);
    res_t r;
    int lz, k, ei;
    logic [SUM_W-1:0] w;
    bit addp;
    r = mk('0, 0, 1'b0, 1'b0, 3'b000, tag);
    lz = SUM_W;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (sum[i]) begin lz = SUM_W - 1 - i; break; end
    end
    addp = (s1 == s2) || z;
    ei = int'(er);
    k = 0;
    if (er == 0) begin
      r.e = sum[SUM_W-1] ? XW'(1) : XW'(0);
    end else if (sum == 0 && !c) begin
      return r;
    end else if (addp && c) begin
      r.mant = sum[47:25];
      r.grs  = {sum[24], sum[23], (sum[22:0] != 0) | st};
      r.e    = XW'(ei + 1);
      r.of   = (r.e >= XW'(255));
      return r;
    end else if (addp) begin
      r.e = sum[SUM_W-1] ? er : XW'(0);
    end else if (lz < ei) begin
      k = lz; r.e = XW'(ei - lz);
    end else begin
      r.uf = 1'b1; r.e = '0; k = ei - 1;
    end
    w = sum << k;
    r.mant = w[46:24];
    r.grs  = {w[23], w[22], (w[21:0] != 0) | st};
    r.of   = (r.e >= XW'(255));
    return r;
  endfunction

  // Monitor: compares every result the consumer takes.
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_output", 64'(out_tag), 64'hFFFF);
      end else begin
        mon_e = sb.pop_front();
        $display("txn tag=%0d mant=%06h exp=%0d uf=%0b of=%0b grs=%03b", out_tag,
                 mantissa_norm, exp_norm, underflow, overflow, grs);
        check_val("tag", 64'(out_tag), 64'(mon_e.tag));
        check_val("mantissa_norm", 64'(mantissa_norm), 64'(mon_e.mant));
        check_val("exp_norm", 64'(exp_norm), 64'(mon_e.e));
        check_val("underflow", 64'(underflow), 64'(mon_e.uf));
        check_val("overflow", 64'(overflow), 64'(mon_e.of));
        check_val("grs", 64'(grs), 64'(mon_e.grs));
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Random back-pressure for the random phase.
  always @(negedge clk) begin
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Drive one operation (called at a negedge), wait for acceptance, push the
  // expectation. Leaves in_valid high so calls can run back to back.
  task automatic send(input logic s1, input logic s2, input logic z, input logic c,
                      input logic [SUM_W-1:0] sum, input logic [XW-1:0] er,
                      input logic st, input logic [TAG_W-1:0] tag, input res_t expv);
    int n;
    sign1 = s1; sign2 = s2; zero = z; carry = c;
    mantissa_sum = sum; exp_res = er; sticky_in = st; in_tag = tag;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) check_val("accept_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(expv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_m(input logic s1, input logic s2, input logic z, input logic c,
                        input logic [SUM_W-1:0] sum, input logic [XW-1:0] er,
                        input logic st, input logic [TAG_W-1:0] tag);
    send(s1, s2, z, c, sum, er, st, tag, model(s1, s2, z, c, sum, er, st, tag));
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  logic [MAN_W-1:0] held_mant;
  logic [SUM_W-1:0] rs;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign1 = 0; sign2 = 0; zero = 0; carry = 0;
    mantissa_sum = '0; exp_res = '0; sticky_in = 0; in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_outputs", 64'({mantissa_norm, exp_norm, underflow, overflow, grs, out_tag}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, back to back with the consumer always ready.
    send(0, 0, 0, 1, 48'hC000_0000_0001, 10'd127, 0, 4'd1, mk(23'h600000, 128, 0, 0, 3'b001, 4'd1));
    send(0, 0, 0, 1, 48'hC000_0000_0001, 10'd254, 0, 4'd2, mk(23'h600000, 255, 0, 1, 3'b001, 4'd2));
    send(0, 1, 0, 0, (48'd1 << 44) | (48'd1 << 20), 10'd100, 0, 4'd3, mk(23'h000000, 97, 0, 0, 3'b100, 4'd3));
    send(0, 1, 0, 0, 48'd1 << 40, 10'd5, 0, 4'd4, mk(23'h100000, 0, 1, 0, 3'b000, 4'd4));
    send(0, 1, 0, 0, 48'h4000_0000_0000, 10'd1, 0, 4'd5, mk(23'h400000, 0, 1, 0, 3'b000, 4'd5));
    send(0, 1, 0, 0, 48'h0, 10'd50, 0, 4'd6, mk(23'h000000, 0, 0, 0, 3'b000, 4'd6));
    send(0, 1, 0, 0, 48'h8000_0100_0000, 10'd0, 1, 4'd7, mk(23'h000001, 1, 0, 0, 3'b001, 4'd7));
    send(1, 1, 0, 0, 48'h8000_00C0_0000, 10'd200, 0, 4'd8, mk(23'h000000, 200, 0, 0, 3'b110, 4'd8));
    drain();

    // Back-pressure: two accepted, third stalls, outputs hold.
    out_ready = 1'b0;
    send_m(0, 0, 0, 1, 48'hC000_0000_0001, 10'd127, 0, 4'd1);
    send_m(0, 1, 0, 0, (48'd1 << 44) | (48'd1 << 20), 10'd100, 0, 4'd2);
    in_tag = 4'd3;
    #1;
    check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
    held_mant = mantissa_norm;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_val("bp_hold_valid", 64'(out_valid), 64'd1);
      check_val("bp_hold_tag", 64'(out_tag), 64'd1);
      check_val("bp_hold_mant", 64'(mantissa_norm), 64'(held_mant));
    end
    @(negedge clk);
    out_ready = 1'b1;
    pop_cyc.delete();
    send_m(0, 1, 0, 0, 48'd1 << 40, 10'd5, 0, 4'd3);
    drain();
    if (pop_cyc.size() == 3) begin
      check_val("bp_consecutive_1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      check_val("bp_consecutive_2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end else begin
      check_val("bp_pop_count", 64'(pop_cyc.size()), 64'd3);
    end

    // Reset with both stages occupied flushes everything.
    out_ready = 1'b0;
    send_m(0, 0, 0, 1, 48'hC000_0000_0001, 10'd127, 0, 4'd9);
    send_m(0, 0, 0, 1, 48'hC000_0000_0001, 10'd127, 0, 4'd10);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    check_val("flush_outputs", 64'({mantissa_norm, exp_norm, underflow, overflow, grs, out_tag}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    send(0, 1, 0, 0, (48'd1 << 44) | (48'd1 << 20), 10'd100, 0, 4'd11,
         mk(23'h000000, 97, 0, 0, 3'b100, 4'd11));
    in_valid = 1'b0;
    #1;
    check_val("latency_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk); #1;
    check_val("latency_two", 64'(out_valid), 64'd1);
    drain();

    // Random operations under random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rs = SUM_W'({$urandom, $urandom}) >> $urandom_range(0, 49);
      send_m(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rs,
             ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 8)) : XW'($urandom_range(0, 1023)),
             1'($urandom_range(0, 1)), TAG_W'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
